// File: rtl/freq_meter.sv
// Gated frequency counter: counts synchronized rising edges of iSig over a
// window of GATE_CYCLES system clocks and reports the count with a one-cycle
// valid strobe. Supports single-shot and back-to-back (continuous) windows.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | counters held at zero, waiting for iStart or iCont
// GATE  | window open, gate counter running, edges counted
// DONE  | one cycle: result presented (oValid), counters cleared
module freq_meter #(
   parameter int GATE_CYCLES = 50_000_000,
   parameter int GATE_W      = 26,
   parameter int EDGE_W      = 24
) (
   input  logic              iClk,
   input  logic              iRst_n,
   input  logic              iSig,
   input  logic              iStart,
   input  logic              iCont,
   output logic [EDGE_W-1:0] oFreq,
   output logic              oValid,
   output logic              oOvf,
   output logic              oBusy
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] GATE = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);
   localparam logic [EDGE_W-1:0] EDGE_MAX  = '1;

   logic [1:0]        state;
   logic              s1, s2, s3;
   logic              rise;
   logic [GATE_W-1:0] gate_cnt;
   logic [EDGE_W-1:0] edge_cnt;
   logic [EDGE_W-1:0] edge_next;
   logic              gate_last;
   logic [EDGE_W-1:0] freq;
   logic              ovf;

   // Two-flop synchronizer plus edge register; runs regardless of state.
   always_ff @(posedge iClk or negedge iRst_n) begin
      if (!iRst_n) begin
         s1 <= 1'b0;
         s2 <= 1'b0;
         s3 <= 1'b0;
      end else begin
         s1 <= iSig;
         s2 <= s1;
         s3 <= s2;
      end
   end

   assign rise      = s2 & ~s3;
   assign gate_last = (gate_cnt == GATE_LAST);

   // Saturating edge increment; the terminal gate cycle's edge is included.
   always_comb begin
      edge_next = edge_cnt;
      if (rise && (edge_cnt != EDGE_MAX)) begin
         edge_next = edge_cnt + 1'b1;
      end
   end

   // Window sequencing and the gate/edge counters.
   always_ff @(posedge iClk or negedge iRst_n) begin
      if (!iRst_n) begin
         state    <= IDLE;
         gate_cnt <= '0;
         edge_cnt <= '0;
      end else begin
         case (state)
            IDLE: begin
               gate_cnt <= '0;
               edge_cnt <= '0;
               if (iStart || iCont) begin
                  state <= GATE;
               end
            end
            GATE: begin
               if (gate_last) begin
                  state <= DONE;
               end else begin
                  gate_cnt <= gate_cnt + 1'b1;
                  edge_cnt <= edge_next;
               end
            end
            DONE: begin
               gate_cnt <= '0;
               edge_cnt <= '0;
               state    <= iCont ? GATE : IDLE;
            end
            default: begin
               state    <= IDLE;
               gate_cnt <= '0;
               edge_cnt <= '0;
            end
         endcase
      end
   end

   // Result register: updated only at the close of a window, held otherwise.
   always_ff @(posedge iClk or negedge iRst_n) begin
      if (!iRst_n) begin
         freq <= '0;
         ovf  <= 1'b0;
      end else if ((state == GATE) && gate_last) begin
         freq <= edge_next;
         ovf  <= (edge_next == EDGE_MAX);
      end
   end

   assign oFreq  = freq;
   assign oOvf   = ovf;
   assign oValid = (state == DONE);
   assign oBusy  = (state != IDLE);

endmodule

// File: tb/tb_freq_meter.sv
// Scoreboard bench for freq_meter: stimulus pushes the expected result and
// the cycle it must appear in; a monitor pops on every oValid and compares.
module tb_freq_meter;

   localparam int GC = 100;
   localparam int GW = 7;
   localparam int EW = 4;

   typedef struct {
      int          cyc;
      logic [EW-1:0] freq;
      logic        ovf;
   } exp_t;

   logic          iClk;
   logic          iRst_n;
   logic          iSig;
   logic          iStart;
   logic          iCont;
   logic [EW-1:0] oFreq;
   logic          oValid;
   logic          oOvf;
   logic          oBusy;

   exp_t exp_q[$];
   int   total = 0;
   int   bad   = 0;
   int   cyc   = 0;
   int   sig_period = 0;
   logic sig_level  = 1'b0;

   freq_meter #(.GATE_CYCLES(GC), .GATE_W(GW), .EDGE_W(EW)) dut (
      .iClk  (iClk),
      .iRst_n(iRst_n),
      .iSig  (iSig),
      .iStart(iStart),
      .iCont (iCont),
      .oFreq (oFreq),
      .oValid(oValid),
      .oOvf  (oOvf),
      .oBusy (oBusy)
   );

   initial begin
      iClk = 1'b0;
      forever #5 iClk = ~iClk;
   end

   initial begin
      forever begin
         @(posedge iClk);
         cyc++;
      end
   end

   // Periodic or constant iSig, changing 2 time units after each rising edge.
   initial begin
      int ph;
      ph   = 0;
      iSig = 1'b0;
      forever begin
         @(posedge iClk);
         #2;
         if (sig_period == 0) begin
            iSig = sig_level;
         end else begin
            ph   = (ph + 1) % sig_period;
            iSig = (ph < sig_period / 2);
         end
      end
   end

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic wait_until(input int c);
      while (cyc < c) begin
         @(posedge iClk);
         #1;
      end
   endtask

   task automatic expect_result(input int c, input int f, input int o);
      exp_t e;
      e.cyc  = c;
      e.freq = EW'(f);
      e.ovf  = o[0];
      exp_q.push_back(e);
   endtask

   // Pulse iStart for one edge; t returns the cycle number of the sampling edge.
   task automatic start_pulse(output int t);
      @(posedge iClk);
      #1 iStart = 1'b1;
      t = cyc + 1;
      @(posedge iClk);
      #1 iStart = 1'b0;
   endtask

   // Monitor: every oValid must match the head of the scoreboard.
   initial begin
      exp_t e;
      forever begin
         @(negedge iClk);
         if (iRst_n && oValid) begin
            if (exp_q.size() == 0) begin
               check("unexpected_valid", 1, 0);
            end else begin
               e = exp_q.pop_front();
               check("valid_cycle", cyc, e.cyc);
               check("freq", int'(oFreq), int'(e.freq));
               check("ovf", int'(oOvf), int'(e.ovf));
               check("busy_in_done", int'(oBusy), 1);
            end
         end
      end
   end

   initial begin
      int t;
      iRst_n = 1'b0;
      iStart = 1'b0;
      iCont  = 1'b0;

      // Reset with a toggling input.
      sig_period = 4;
      repeat (6) @(posedge iClk);
      #1;
      check("rst_freq", int'(oFreq), 0);
      check("rst_valid", int'(oValid), 0);
      check("rst_ovf", int'(oOvf), 0);
      check("rst_busy", int'(oBusy), 0);
      iRst_n = 1'b1;
      wait_until(cyc + 20);
      check("idle_busy", int'(oBusy), 0);
      check("idle_freq", int'(oFreq), 0);

      // Single shot, period 10.
      sig_period = 10;
      wait_until(cyc + 30);
      start_pulse(t);
      expect_result(t + GC, 10, 0);
      check("busy_after_start", int'(oBusy), 1);
      wait_until(t + GC + 1);
      check("busy_after_done", int'(oBusy), 0);
      check("freq_held", int'(oFreq), 10);

      // Saturation, then a non-saturating window clears the flag.
      sig_period = 4;
      wait_until(cyc + 30);
      start_pulse(t);
      expect_result(t + GC, 15, 1);
      wait_until(t + GC + 1);
      sig_period = 20;
      wait_until(cyc + 30);
      start_pulse(t);
      expect_result(t + GC, 5, 0);
      wait_until(t + GC + 1);

      // Continuous mode, dropped half way through the third window.
      @(posedge iClk);
      #1 iCont = 1'b1;
      t = cyc + 1;
      expect_result(t + GC, 5, 0);
      expect_result(t + 2 * GC + 1, 5, 0);
      expect_result(t + 3 * GC + 2, 5, 0);
      wait_until(t + 2 * GC + 2 + 50);
      iCont = 1'b0;
      wait_until(t + 3 * GC + 3);
      check("cont_busy_end", int'(oBusy), 0);
      check("cont_freq_held", int'(oFreq), 5);
      check("queue_drained_cont", exp_q.size(), 0);

      // Reset in the middle of a gate window.
      start_pulse(t);
      wait_until(t + 50);
      iRst_n = 1'b0;
      #1;
      check("midrst_freq", int'(oFreq), 0);
      check("midrst_ovf", int'(oOvf), 0);
      check("midrst_busy", int'(oBusy), 0);
      check("midrst_valid", int'(oValid), 0);
      wait_until(cyc + 3);
      iRst_n = 1'b1;
      wait_until(cyc + 150);
      check("midrst_idle_busy", int'(oBusy), 0);

      // Constant-high input and a second iStart during GATE.
      sig_period = 0;
      sig_level  = 1'b1;
      wait_until(cyc + 10);
      start_pulse(t);
      expect_result(t + GC, 0, 0);
      wait_until(t + 30);
      iStart = 1'b1;
      @(posedge iClk);
      #1 iStart = 1'b0;
      wait_until(t + GC + 150);
      check("dc_busy_end", int'(oBusy), 0);
      check("queue_drained_end", exp_q.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/freq_meter.md
# freq_meter

Gated frequency counter, the measuring counterpart of the team's clock divisor. It counts rising edges of an asynchronous input signal over a fixed window of GATE_CYCLES system clocks and reports the count as a registered result with a one-cycle valid strobe. It sits beside the divisor chain to check divided clocks and external pulse trains against the system clock. It runs single-shot or back-to-back.

## Interface
- GATE_CYCLES, 50_000_000: gate window length in iClk cycles (≥ 2).
- GATE_W, 26: gate counter width; must hold GATE_CYCLES-1.
- EDGE_W, 24: result width.
- iClk  input  1  system clock; all state on rising edge.
- iRst_n  input  1  reset; one clock; reset is asynchronous and active-low.
- iSig  input  1  signal under measurement, asynchronous to iClk.
- iStart  input  1  start request; sampled only in IDLE.
- iCont  input  1  continuous mode; sampled in IDLE and DONE.
- oFreq  output  EDGE_W  edge count of last completed window.
- oValid  output  1  one-cycle strobe: oFreq/oOvf just updated.
- oOvf  output  1  last window's count saturated.
- oBusy  output  1  high in GATE and DONE.

## Operation
- Input path: 2-flop synchronizer (s1, s2), then edge register s3. Rising edge = s2 & ~s3. s1..s3 run in every state.
- States: IDLE, GATE, DONE.
- IDLE: gate and edge counters held at 0. If iStart or iCont is high, go to GATE.
- GATE: gate counter increments each cycle. Edge counter increments on each detected edge and saturates at 2^EDGE_W-1. When the gate counter equals GATE_CYCLES-1, that cycle's edge is still counted; latch the final count into oFreq and the saturation flag into oOvf, then go to DONE.
- DONE: lasts one cycle. oValid = 1 and both counters clear.
  - If iCont is high, go to GATE.
  - Otherwise go to IDLE.
- Edges detected in IDLE or DONE are not counted. Continuous mode therefore has 1 dead cycle per window.
- iStart outside IDLE is ignored and not queued.
- Dropping iCont mid-window does not abort; the current window completes and reports.
- oFreq/oOvf hold their values until the next DONE.
- Saturation: once the edge counter reaches all-ones it stays there and oOvf is set at latch time. oOvf is cleared at the next latch if that window does not saturate.
- Input constraint: iSig high and low phases each ≥ 2 iClk periods for guaranteed counting. Faster inputs undercount; this is not flagged.

## Timing
- Reset (async, immediate): state IDLE, s1..s3 = 0, counters 0, oFreq = 0, oValid = 0, oOvf = 0, oBusy = 0.
- Reset mid-window discards the window. No oValid is issued after release until a new start.
- iStart high at edge T (in IDLE): GATE occupies cycles T+1 … T+GATE_CYCLES; DONE is cycle T+GATE_CYCLES+1.
- oValid high exactly in the DONE cycle, with oFreq/oOvf already showing the new values.
- oBusy asserts from cycle T+1 and deasserts the cycle after DONE (single-shot).
- Continuous mode: oValid period = GATE_CYCLES+1 cycles.
- Edge latency: an iSig rise is counted on the 3rd iClk edge after it is captured by s1. A rise landing in the last 2 GATE cycles is counted in a later window, or lost in single-shot.
- A window of N cycles over a clean periodic input of period P (N a multiple of P) yields exactly N/P for any phase.

## Test plan
- Reset: hold iRst_n = 0 with iSig toggling → oFreq = 0, oValid = 0, oOvf = 0, oBusy = 0; no change for 20 cycles after release without iStart.
- Single shot: GATE_CYCLES = 100, iSig period 10 (5/5), iStart pulse at T → oValid one cycle at T+101, oFreq = 10, oOvf = 0, oBusy low from T+102.
- Saturation: EDGE_W = 4, GATE_CYCLES = 100, iSig period 4 → oFreq = 15, oOvf = 1. A following window with period 20 → oFreq = 5, oOvf = 0.
- Continuous: iCont = 1, iSig period 20 → oValid every 101 cycles, each oFreq = 5. Drop iCont at cycle 50 of a window → that window still reports 5, then IDLE with oBusy = 0.
- Reset mid-gate: assert iRst_n low at GATE cycle 50 → outputs zero asynchronously; after release no oValid until a new iStart.
- Ignored start / DC input: iStart re-pulsed during GATE → exactly one oValid. Constant-high iSig → oFreq = 0.
